// File: rtl/xalu_pkg.sv
// Shared op codes, FSM state encoding and op-class helper for the word sequencer.
package xalu_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_PASSA = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_SHR   = 3'd6;
  localparam logic [2:0] OP_SHL   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops whose slice carry ripples between nibbles and produces a word carry-out.
  function automatic logic op_uses_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/xalu_word_seq.sv
// Runs an external 4-bit ALU slice over NIB cycles to perform one 4*NIB-bit word operation,
// chaining carries between nibbles and assembling result, carry-out and flags.
module xalu_word_seq
  import xalu_pkg::*;
#(
  parameter int unsigned NIB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              com,
  input  logic              cin,
  input  logic [4*NIB-1:0]  a_word,
  input  logic [4*NIB-1:0]  b_word,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [2:0]        alu_f,
  output logic              alu_ci_right,
  output logic              alu_ci_left,
  output logic              alu_com,
  input  logic [3:0]        alu_d,
  input  logic              alu_co_left,
  input  logic              alu_co_right,
  input  logic              alu_equ,
  output logic              busy,
  output logic              done,
  output logic [4*NIB-1:0]  result,
  output logic              cout,
  output logic              eq,
  output logic              zero
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned IW = $clog2(NIB);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      op_q, op_d;
  logic            com_q, com_d;
  logic            carry_q, carry_d;
  logic            eq_acc_q, eq_acc_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cout_q, cout_d;
  logic            eq_q, eq_d;
  logic            zero_q, zero_d;

  logic [IW-1:0]   pos;
  logic [3:0]      nib_a, nib_b;
  logic            run;
  logic            last;

  // Nibble position: SHR walks MSB-first so the shift-in enters at the top.
  always_comb begin
    run   = (state_q == ST_RUN);
    last  = (idx_q == IW'(NIB - 1));
    pos   = (op_q == OP_SHR) ? (IW'(NIB - 1) - idx_q) : idx_q;
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < NIB; i++) begin
      if (pos == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // Slice drive; the carry register already holds cin for the first nibble.
  always_comb begin
    alu_a        = run ? nib_a : 4'd0;
    alu_b        = run ? nib_b : 4'd0;
    alu_f        = run ? op_q : 3'd0;
    alu_com      = run & com_q;
    alu_ci_right = run & carry_q & ((op_q == OP_ADD) || (op_q == OP_SHL));
    alu_ci_left  = run & carry_q & (op_q == OP_SHR);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    com_d    = com_q;
    carry_d  = carry_q;
    eq_acc_d = eq_acc_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    eq_d     = eq_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          idx_d    = '0;
          op_d     = op;
          com_d    = com;
          carry_d  = cin;
          eq_acc_d = 1'b1;
          a_d      = a_word;
          b_d      = b_word;
          result_d = '0;
          busy_d   = 1'b1;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (pos == IW'(i)) result_d[4*i +: 4] = alu_d;
        end
        carry_d  = (op_q == OP_SHR) ? alu_co_right : alu_co_left;
        eq_acc_d = eq_acc_q & alu_equ;
        idx_d    = idx_q + IW'(1);
        if (last) begin
          state_d = ST_DONE;
          idx_d   = '0;
          done_d  = 1'b1;
          cout_d  = op_uses_carry(op_q) & carry_d;
          eq_d    = eq_acc_d;
          zero_d  = ~|result_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      op_q     <= 3'd0;
      com_q    <= 1'b0;
      carry_q  <= 1'b0;
      eq_acc_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      eq_q     <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      com_q    <= com_d;
      carry_q  <= carry_d;
      eq_acc_q <= eq_acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      eq_q     <= eq_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign eq     = eq_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_xalu_word_seq.sv
// Bench for xalu_word_seq: behavioural 4-bit slice plus a word-level reference model.
module tb_xalu_word_seq;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic         com;
  logic         cin;
  logic [W-1:0] a_word, b_word;
  logic [3:0]   alu_a, alu_b, alu_d;
  logic [2:0]   alu_f;
  logic         alu_ci_right, alu_ci_left, alu_com;
  logic         alu_co_left, alu_co_right, alu_equ;
  logic         busy, done, cout, eq, zero;
  logic [W-1:0] result;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  xalu_word_seq #(.NIB(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .com(com), .cin(cin),
    .a_word(a_word), .b_word(b_word),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_ci_right(alu_ci_right),
    .alu_ci_left(alu_ci_left), .alu_com(alu_com), .alu_d(alu_d),
    .alu_co_left(alu_co_left), .alu_co_right(alu_co_right), .alu_equ(alu_equ),
    .busy(busy), .done(done), .result(result), .cout(cout), .eq(eq), .zero(zero)
  );

  // Combinational 4-bit slice as seen by the sequencer.
  logic [4:0] slice_sum;
  logic [3:0] slice_raw;
  always_comb begin
    slice_sum    = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_ci_right);
    slice_raw    = 4'd0;
    alu_co_left  = 1'b0;
    alu_co_right = 1'b0;
    case (alu_f)
      3'd0: begin slice_raw = slice_sum[3:0]; alu_co_left = slice_sum[4]; end
      3'd1: slice_raw = alu_a & alu_b;
      3'd2: slice_raw = alu_a | alu_b;
      3'd3: slice_raw = alu_a ^ alu_b;
      3'd4: slice_raw = alu_a;
      3'd5: slice_raw = alu_b;
      3'd6: begin slice_raw = {alu_ci_left, alu_a[3:1]}; alu_co_right = alu_a[0]; end
      default: begin slice_raw = {alu_a[2:0], alu_ci_right}; alu_co_left = alu_a[3]; end
    endcase
    alu_d   = alu_com ? ~slice_raw : slice_raw;
    alu_equ = (alu_a == alu_b);
  end

  // Word-level reference: returns {cout, result}.
  function automatic logic [W:0] ref_model(input logic [2:0] o, input logic c, input logic ci,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         co;
    co = 1'b0;
    case (o)
      3'd0: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(ci); r = s[W-1:0]; co = s[W]; end
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = a;
      3'd5: r = b;
      3'd6: begin r = {ci, a[W-1:1]}; co = a[0]; end
      default: begin r = {a[W-2:0], ci}; co = a[W-1]; end
    endcase
    if (c) r = ~r;
    return {co, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one command; optionally fire a second start mid-RUN that must be ignored.
  task automatic run_op(input logic [2:0] o, input logic c, input logic ci,
                        input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    logic [W:0] exp;
    int n;
    exp = ref_model(o, c, ci, a, b);
    @(negedge clk);
    op = o; com = c; cin = ci; a_word = a; b_word = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_word = W'($urandom); b_word = W'($urandom); cin = ~ci;
    n = 0;
    while (n < 20 && !done) begin
      if (inject && n == 1) begin
        start = 1'b1; op = 3'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk("latency", 32'(n), 32'(NIB));
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("result", 32'(result), 32'(exp[W-1:0]));
    chk("cout", 32'(cout), 32'(exp[W]));
    chk("eq", 32'(eq), 32'(a == b));
    chk("zero", 32'(exp[W-1:0] == '0), 32'(zero));
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("result_held", 32'(result), 32'(exp[W-1:0]));
    chk("alu_f_idle", 32'(alu_f), 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; com = 1'b0; cin = 1'b0;
    a_word = '0; b_word = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({cout, eq, zero}), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left, alu_com}), 32'd0);
    rst_n = 1'b1;

    run_op(3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
    run_op(3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(3'd6, 1'b0, 1'b1, 16'h8001, 16'h0000, 1'b0);
    run_op(3'd7, 1'b0, 1'b0, 16'h8001, 16'h0000, 1'b0);
    run_op(3'd3, 1'b1, 1'b0, 16'hA5A5, 16'hA5A5, 1'b0);
    run_op(3'd1, 1'b0, 1'b0, 16'hA5A5, 16'h5A5A, 1'b0);
    run_op(3'd0, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1);

    // Reset in the third RUN cycle abandons the op without a done pulse.
    @(negedge clk);
    op = 3'd0; com = 1'b0; cin = 1'b0; a_word = 16'h1111; b_word = 16'h2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_alu_f", 32'(alu_f), 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    run_op(3'd0, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      run_op(3'($urandom), 1'($urandom), 1'($urandom), ra, rb, 1'($urandom));
    end

    // Back-to-back start held high: exactly one done per NIB+2 cycles.
    @(negedge clk);
    op = 3'd2; com = 1'b0; a_word = 16'h00F0; b_word = 16'h0F00; start = 1'b1;
    dones = 0;
    n = 0;
    for (int i = 0; i < 3 * (NIB + 2); i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    start = 1'b0;
    chk("b2b_dones", 32'(dones), 32'd3);
    chk("b2b_result", 32'(result), 32'h0FF0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
